// File: rtl/regfile_dump_tx.sv
// Purpose: on a start pulse, read every CPU register through a synchronous read port and
//          transmit it over an 8N1 UART line as "ii:hhhhhhhh\r\n" (13 bytes per register).
// Latency: first start bit 3 cycles after start; line period 130*CLKS_PER_BIT+3 cycles.
// Backpressure: none; start is ignored while busy (and in the done cycle), never queued.
// Ports: clk, reset (sync, active-high), start; reg_addr/reg_data = register read port
//        (data valid one cycle after address); uart_tx = serial out; busy, done = status.
module regfile_dump_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_REGS     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]     REG_LAST = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_SEND,
        S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;     // 0 = start bit, 1..8 = data, 9 = stop
    logic [3:0]    char_idx;    // 0..12 within the line
    logic [4:0]    reg_idx;
    logic [31:0]   hold;        // snapshot of the register being printed

    logic bit_end, byte_end, last_char, last_reg;

    assign bit_end   = (clk_cnt == CLK_LAST);
    assign byte_end  = bit_end && (bit_cnt == 4'd9);
    assign last_char = (char_idx == 4'd12);
    assign last_reg  = (reg_idx == REG_LAST);

    // ---------------------------------------------------------------
    // Character generation for the current char_idx
    // ---------------------------------------------------------------
    logic [1:0] tens;
    logic [3:0] ones;
    logic [3:0] nib_shift;
    logic [3:0] nib;
    logic [7:0] hex_chr;
    logic [7:0] char_byte;

    always_comb begin
        tens = 2'd0;
        ones = 4'(reg_idx);
        // Decimal split by range compare: index never exceeds 31.
        if (reg_idx >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(reg_idx - 5'd30);
        end else if (reg_idx >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(reg_idx - 5'd20);
        end else if (reg_idx >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(reg_idx - 5'd10);
        end

        // Chars 3..10 are nibbles 7..0 (MSB first).
        nib_shift = 4'd10 - char_idx;
        nib       = 4'(hold >> {nib_shift[2:0], 2'b00});
        hex_chr   = (nib < 4'd10) ? (8'h30 + {4'd0, nib}) : (8'h57 + {4'd0, nib});

        case (char_idx)
            4'd0:    char_byte = 8'h30 + {6'd0, tens};
            4'd1:    char_byte = 8'h30 + {4'd0, ones};
            4'd2:    char_byte = 8'h3A;
            4'd11:   char_byte = 8'h0D;
            4'd12:   char_byte = 8'h0A;
            default: char_byte = hex_chr;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR:  state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_SEND;
            S_SEND: begin
                if (byte_end && last_char) begin
                    state_nxt = last_reg ? S_FIN : S_ADDR;
                end
            end
            S_FIN: begin
                // busy drops on the same edge that raises done; start here is ignored
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath: address, snapshot, bit/char counters, serial output
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_tx  <= 1'b1;
            reg_addr <= 5'd0;
            reg_idx  <= 5'd0;
            clk_cnt  <= '0;
            bit_cnt  <= 4'd0;
            char_idx <= 4'd0;
            hold     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        reg_idx <= 5'd0;
                    end
                end
                S_ADDR: begin
                    reg_addr <= reg_idx;
                end
                S_LATCH: begin
                    hold     <= reg_data;
                    char_idx <= 4'd0;
                    clk_cnt  <= '0;
                    bit_cnt  <= 4'd0;
                    uart_tx  <= 1'b0;   // first start bit of the line
                end
                S_SEND: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= 4'd0;
                            if (!last_char) begin
                                // next byte of the line follows with no idle gap
                                char_idx <= char_idx + 4'd1;
                                uart_tx  <= 1'b0;
                            end else begin
                                uart_tx <= 1'b1;
                                if (!last_reg) begin
                                    reg_idx <= reg_idx + 5'd1;
                                end
                            end
                        end else begin
                            // bit_cnt k ending -> data bit k next, or stop after bit 7
                            bit_cnt <= bit_cnt + 4'd1;
                            uart_tx <= (bit_cnt == 4'd8) ? 1'b1 : char_byte[bit_cnt[2:0]];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_tx.sv
module tb_regfile_dump_tx;

    localparam int CPB     = 4;
    localparam int LINE_CY = 130 * CPB + 3;

    logic        clk;
    logic        reset;
    logic        start32, start1;
    logic [4:0]  reg_addr32, reg_addr1;
    logic [31:0] reg_data32, reg_data1;
    logic        tx32, tx1, busy32, busy1, done32, done1;

    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start32),
        .reg_addr (reg_addr32),
        .reg_data (reg_data32),
        .uart_tx  (tx32),
        .busy     (busy32),
        .done     (done32)
    );

    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(1)) dut_one (
        .clk      (clk),
        .reset    (reset),
        .start    (start1),
        .reg_addr (reg_addr1),
        .reg_data (reg_data1),
        .uart_tx  (tx1),
        .busy     (busy1),
        .done     (done1)
    );

    logic [31:0] regs [32];
    logic [7:0]  exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          start_edge = 0;
    int          nbytes = 0;
    int          last_end = 0;
    int          busy_falls = 0;
    bit          sel = 0;        // 0: watch 32-register dut, 1: single-register dut
    bit          mon_en = 0;
    logic        mon_tx, mon_busy;

    assign mon_tx   = sel ? tx1 : tx32;
    assign mon_busy = sel ? busy1 : busy32;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Register file model with one-cycle synchronous read
    initial forever begin
        @(posedge clk);
        reg_data32 <= regs[reg_addr32];
        reg_data1  <= regs[reg_addr1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_dump(input int n);
        string s;
        for (int i = 0; i < n; i++) begin
            s = $sformatf("%02d:%08h", i, regs[i]);
            for (int j = 0; j < 11; j++) exp_q.push_back(s[j]);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic do_start(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1; else start32 = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start1  = 1'b0;
        start32 = 1'b0;
        check("busy_rise", which ? busy1 : busy32, 1'b1);
    endtask

    task automatic wait_done(input bit which, input int limit, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (which ? done1 : done32) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // UART monitor: decodes bytes, checks bit stability and inter-byte gaps
    initial begin
        int   mst, bit_i, smp;
        logic bv, ok, prev_busy;
        logic [9:0] frame;
        mst = 0; bit_i = 0; smp = 0; bv = 1'b0; ok = 1'b1; frame = '0; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_busy && !mon_busy) busy_falls++;
            prev_busy = mon_busy;
            if (!mon_en) begin
                mst = 0;
            end else if (mst == 0) begin
                if (mon_tx == 1'b0) begin
                    mst = 1; bit_i = 0; smp = 1; bv = 1'b0; ok = 1'b1; frame = '0;
                    if (nbytes == 0) check("first_start", cyc - start_edge, 3);
                    else check("gap", cyc - last_end - 1, (nbytes % 13 == 0) ? 3 : 0);
                end
            end else begin
                if (smp == 0) bv = mon_tx;
                else if (mon_tx !== bv) ok = 1'b0;
                smp++;
                if (smp == CPB) begin
                    frame[bit_i] = bv;
                    bit_i++;
                    smp = 0;
                    if (bit_i == 10) begin
                        mst = 0;
                        last_end = cyc;
                        check("bit_hold", ok, 1'b1);
                        check("stop_bit", frame[9], 1'b1);
                        if (exp_q.size() == 0) check("extra_byte", 32'(frame[8:1]), 32'h100);
                        else check($sformatf("byte%0d", nbytes), frame[8:1], exp_q.pop_front());
                        nbytes++;
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        reset = 1'b1; start32 = 1'b0; start1 = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0]  = 32'h0;
        regs[5]  = 32'h0000002a;
        regs[10] = 32'hffffffff;
        regs[31] = 32'hdeadbeef;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx", tx32, 1'b1);
        check("rst_busy", busy32, 1'b0);
        check("rst_done", done32, 1'b0);
        check("rst_addr", reg_addr32, 5'd0);
        check("rst_tx_one", tx1, 1'b1);

        // Single-register frame
        sel = 1; mon_en = 1; nbytes = 0; busy_falls = 0;
        push_dump(1);
        do_start(1);
        wait_done(1, 1000, seen);
        check("one_done_seen", seen, 1'b1);
        check("one_done_lat", cyc - start_edge, LINE_CY);
        check("one_busy_at_done", busy1, 1'b0);
        @(negedge clk);
        check("one_done_width", done1, 1'b0);
        check("one_q_empty", exp_q.size(), 0);
        check("one_nbytes", nbytes, 13);

        // Full 32-register dump with start-while-busy and snapshot change
        sel = 0; nbytes = 0; busy_falls = 0;
        repeat (4) @(negedge clk);
        push_dump(32);
        do_start(0);
        seen = 1'b0;
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk);
            if (k == 1) check("addr_first", reg_addr32, 5'd0);
            if (k == 1500) start32 = 1'b1;
            if (k == 1501) start32 = 1'b0;
            if (k == 3 + 7 * LINE_CY + 20) regs[7] = ~regs[7];
            if (done32) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1'b1);
        check("done_lat", cyc - start_edge, 32 * LINE_CY);
        check("busy_at_done", busy32, 1'b0);
        check("addr_last", reg_addr32, 5'd31);
        start32 = 1'b1;            // start during the done cycle must be ignored
        @(negedge clk);
        start32 = 1'b0;
        check("done_width", done32, 1'b0);
        repeat (20) @(negedge clk);
        check("no_restart", busy32, 1'b0);
        check("tx_idle", tx32, 1'b1);
        check("busy_falls", busy_falls, 1);
        check("q_empty", exp_q.size(), 0);
        check("nbytes", nbytes, 32 * 13);

        // Reset during a data bit, with start asserted alongside reset
        mon_en = 0;
        do_start(0);
        repeat (14) @(negedge clk);
        reset = 1'b1; start32 = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", tx32, 1'b1);
        check("mid_rst_busy", busy32, 1'b0);
        check("mid_rst_done", done32, 1'b0);
        check("mid_rst_addr", reg_addr32, 5'd0);
        reset = 1'b0; start32 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_beats_start", busy32, 1'b0);

        // Fresh dump after reset
        exp_q.delete();
        nbytes = 0; busy_falls = 0; mon_en = 1;
        push_dump(32);
        do_start(0);
        wait_done(0, 20000, seen);
        check("re_done_seen", seen, 1'b1);
        check("re_done_lat", cyc - start_edge, 32 * LINE_CY);
        repeat (3) @(negedge clk);
        check("re_q_empty", exp_q.size(), 0);
        check("re_nbytes", nbytes, 32 * 13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
